// File: rtl/i2c_slave.sv
// I2C target at SLAVE_ADDR: oversampled scl/sda, START/STOP detect, byte shift in/out with ACK.
// Pin edges act SYNC_STAGES+1 clk late; no clock stretching, so tx_data must be valid whenever a read byte loads.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw_dir,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_req_q, tx_req_d;
  logic                   rw_dir_q, rw_dir_d;
  logic                   busy_q, busy_d;
  logic                   start_det_q, start_det_d;
  logic                   stop_det_q, stop_det_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;

  logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_rise   = scl_s & ~scl_prev_q;
    scl_fall   = ~scl_s & scl_prev_q;
    start_c    = scl_s & ~sda_s & sda_prev_q;
    stop_c     = scl_s & sda_s & ~sda_prev_q;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    rw_dir_d    = rw_dir_q;
    busy_d      = busy_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    if (stop_c) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start_c) begin
      // busy is left alone so a repeated START keeps the bus claimed until the address decides
      state_d     = ADDR;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      start_det_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = {shift_q[5:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_q == SLAVE_ADDR) begin
              rw_dir_d = sda_s;
              busy_d   = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          // first falling edge pulls ACK low, the second ends the ACK clock
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (state_q == WR_ACK || !rw_dir_q) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = WR_DATA;
          end else begin
            shift_d   = tx_data[6:0];
            sda_oe_d  = ~tx_data[7];
            tx_req_d  = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = RD_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = {shift_q[5:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {shift_q, sda_s};
            rx_valid_d = 1'b1;
            state_d    = WR_ACK;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = RD_ACK;
          end else begin
            sda_oe_d  = ~shift_q[6];
            shift_d   = {shift_q[5:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        RD_ACK: begin
          // bit_cnt doubles as "master ACK seen" while waiting for the closing falling edge
          if (scl_rise) begin
            if (sda_s) begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end else begin
              bit_cnt_d = 3'd1;
            end
          end else if (scl_fall && bit_cnt_q != 3'd0) begin
            shift_d   = tx_data[6:0];
            sda_oe_d  = ~tx_data[7];
            tx_req_d  = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      rw_dir_q    <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      rw_dir_q    <= rw_dir_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_s;
      sda_prev_q  <= sda_s;
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_req    = tx_req_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rw_dir    = rw_dir_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave; expectations come from the address/byte rules of the protocol.
module tb_i2c_slave;

  localparam logic [6:0] SLV = 7'h42;
  localparam int         Q   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_r = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda;
  logic [7:0] tx_data;
  logic       tx_req, rx_valid, rw_dir, busy, start_det, stop_det;
  logic [7:0] rx_data;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(SLV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl_r), .sda(sda),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .rw_dir(rw_dir), .busy(busy), .start_det(start_det), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int rx_cnt = 0, start_cnt = 0, stop_cnt = 0, ovl_cnt = 0, slave_low = 0;
  logic [7:0]  rx_log [64];
  logic [7:0]  tx_src [16];
  logic [31:0] tx_cnt = 32'd0;
  logic [7:0]  wbuf [8];
  logic [7:0]  rbuf [8];

  // user side: present tx_src in ring order, advancing on every tx_req
  assign tx_data = tx_src[tx_cnt[3:0]];

  initial forever begin
    @(negedge clk);
    if (rx_valid) begin
      rx_log[rx_cnt % 64] = rx_data;
      rx_cnt++;
    end
    if (tx_req) tx_cnt = tx_cnt + 32'd1;
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (rx_valid && tx_req) ovl_cnt++;
    if (sda == 1'b0 && !m_sda_low) slave_low++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_sda_low = !b;
    wq(Q); scl_r = 1'b1;
    wq(Q); s = sda;
    wq(Q); scl_r = 1'b0;
    wq(Q);
  endtask

  task automatic recv_bit(output logic s);
    m_sda_low = 1'b0;
    wq(Q); scl_r = 1'b1;
    wq(Q); s = sda;
    wq(Q); scl_r = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_start();
    if (!scl_r) begin
      m_sda_low = 1'b0;
      wq(Q); scl_r = 1'b1;
      wq(Q);
    end
    wq(Q); m_sda_low = 1'b1;
    wq(2*Q); scl_r = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wq(Q); scl_r = 1'b1;
    wq(2*Q); m_sda_low = 1'b0;
    wq(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(s);
      b[i] = s;
    end
    send_bit(nack, s);
    check("rd_ack_bit_level", s, nack);
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input bit stop_after);
    logic ack;
    bit   m;
    int   rx0, sl0;
    m = (a == SLV);
    rx0 = rx_cnt; sl0 = slave_low;
    i2c_start();
    send_byte({a, 1'b0}, ack);
    check("wr_addr_ack", ack, !m);
    check("wr_busy", busy, m);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      check("wr_data_ack", ack, !m);
    end
    check("wr_rx_count", rx_cnt - rx0, m ? n : 0);
    if (m) begin
      check("wr_rw_dir", rw_dir, 0);
      for (int i = 0; i < n; i++) check("wr_rx_byte", rx_log[(rx0 + i) % 64], wbuf[i]);
      check("wr_rx_data", rx_data, wbuf[n-1]);
    end else begin
      check("wr_no_drive", slave_low - sl0, 0);
    end
    if (stop_after) begin
      i2c_stop();
      check("wr_busy_after_stop", busy, 0);
    end
  endtask

  task automatic do_read(input logic [6:0] a, input int n);
    logic        ack;
    logic [7:0]  b;
    bit          m;
    logic [31:0] c0;
    m = (a == SLV);
    c0 = tx_cnt;
    for (int k = 0; k <= n; k++) tx_src[4'(c0 + k)] = (k < n) ? rbuf[k] : 8'h00;
    i2c_start();
    send_byte({a, 1'b1}, ack);
    check("rd_addr_ack", ack, !m);
    if (m) begin
      check("rd_rw_dir", rw_dir, 1);
      for (int i = 0; i < n; i++) begin
        recv_byte(b, i == n - 1);
        check("rd_byte", b, rbuf[i]);
      end
      check("rd_tx_req_count", tx_cnt - c0, n);
      check("rd_busy_after_nack", busy, 0);
    end
    i2c_stop();
    check("rd_busy_after_stop", busy, 0);
  endtask

  initial begin
    int s0, p0;
    logic [7:0] b8;
    logic       s;
    for (int i = 0; i < 16; i++) tx_src[i] = 8'h00;
    wq(3);
    check("reset_outputs", {busy, rw_dir, rx_valid, tx_req, start_det, stop_det, rx_data}, 0);
    check("reset_sda", sda, 1);
    rst_n = 1'b1;
    wq(4);

    // single write byte
    s0 = start_cnt; p0 = stop_cnt;
    wbuf[0] = 8'hC0;
    do_write(SLV, 1, 1);
    check("t1_start_det", start_cnt - s0, 1);
    check("t1_stop_det", stop_cnt - p0, 1);

    // single read byte, NACKed
    rbuf[0] = 8'hA5;
    do_read(SLV, 1);

    // wrong address
    wbuf[0] = 8'h55;
    do_write(7'h43, 1, 1);

    // three bytes
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(SLV, 3, 1);

    // write then repeated START into a two-byte read
    s0 = start_cnt;
    wbuf[0] = 8'h10;
    do_write(SLV, 1, 0);
    rbuf[0] = 8'h3C; rbuf[1] = 8'hC3;
    do_read(SLV, 2);
    check("t5_rx_data", rx_data, 8'h10);
    check("t5_start_det", start_cnt - s0, 2);

    // reset while the address ACK is driven
    i2c_start();
    b8 = {SLV, 1'b0};
    for (int i = 7; i >= 0; i--) send_bit(b8[i], s);
    m_sda_low = 1'b0;
    wq(1);
    check("rst_ack_driven", sda, 0);
    check("rst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_sda_released", sda, 1);
    check("rst_outputs", {busy, rw_dir, rx_valid, tx_req, start_det, stop_det, rx_data}, 0);
    wq(2);
    rst_n = 1'b1;
    scl_r = 1'b1;
    wq(2*Q);
    wbuf[0] = 8'h5A;
    do_write(SLV, 1, 1);

    // randomized traffic
    for (int it = 0; it < 10; it++) begin
      logic [6:0] a;
      int n;
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : SLV;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        wbuf[i] = 8'($urandom);
        rbuf[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 0) do_write(a, n, 1);
      else do_read(a, n);
    end

    check("no_rx_tx_overlap", ovl_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
